// File: rtl/credential_entry.sv
// credential_entry: keypad front end of the lock datapath.
// Gathers up to eight digits (four username nibbles, then four password
// nibbles), clears on a resetCount rising edge, and handles the unlocker's
// error flag: operator acknowledge for a wrong password, or a timed lockout
// after three failures, followed by a flagResolve handshake.
module credential_entry #(
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       btn_back,
  input  logic       btn_clear,
  input  logic       btn_ack,
  input  logic       resetCount,
  input  logic       flag,
  input  logic       flagSelect,
  output logic [3:0] inputCount,
  output logic [3:0] userNameInput0,
  output logic [3:0] userNameInput1,
  output logic [3:0] userNameInput2,
  output logic [3:0] userNameInput3,
  output logic [3:0] passwordInput0,
  output logic [3:0] passwordInput1,
  output logic [3:0] passwordInput2,
  output logic [3:0] passwordInput3,
  output logic       flagResolve,
  output logic       entry_full,
  output logic       lockout_active
);

  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ENTRY,
    FLAG_HOLD,
    LOCKOUT,
    RESOLVE
  } state_t;

  state_t        state;
  logic [3:0]    count;
  logic [3:0]    slot [8];
  logic [CW-1:0] lock_cnt;
  logic          flag_q;
  logic          rc_q;
  logic          flag_resolve_q;

  logic       flag_rise;
  logic       rc_rise;
  logic [2:0] wr_idx;
  logic [2:0] back_idx;

  // Edge detection against the previous sampled level, and buffer pointers
  assign flag_rise = flag & ~flag_q;
  assign rc_rise   = resetCount & ~rc_q;
  assign wr_idx    = count[2:0];
  assign back_idx  = count[2:0] - 3'd1;

  // Control FSM, buffer and lockout counter; everything updates on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ENTRY;
      count          <= 4'd0;
      lock_cnt       <= '0;
      flag_q         <= 1'b0;
      rc_q           <= 1'b0;
      flag_resolve_q <= 1'b0;
      for (int i = 0; i < 8; i++) slot[i] <= 4'd0;
    end else begin
      // Both unlocker levels are sampled every cycle so that an edge
      // arriving outside ENTRY is consumed rather than replayed later.
      flag_q <= flag;
      rc_q   <= resetCount;
      case (state)
        ENTRY: begin
          if (flag_rise) begin
            // The unlocker re-evaluates while the buffer is full, so the
            // buffer must be emptied before anything else happens.
            count <= 4'd0;
            for (int i = 0; i < 8; i++) slot[i] <= 4'd0;
            if (flagSelect) begin
              lock_cnt <= CW'(LOCKOUT_CYCLES);
              state    <= LOCKOUT;
            end else begin
              state <= FLAG_HOLD;
            end
          end else if (rc_rise || btn_clear) begin
            count <= 4'd0;
            for (int i = 0; i < 8; i++) slot[i] <= 4'd0;
          end else if (btn_back) begin
            if (count != 4'd0) begin
              slot[back_idx] <= 4'd0;
              count          <= count - 4'd1;
            end
          end else if (digit_valid) begin
            if (count != 4'd8) begin
              slot[wr_idx] <= digit;
              count        <= count + 4'd1;
            end
          end
        end
        FLAG_HOLD: begin
          if (btn_ack) begin
            flag_resolve_q <= 1'b1;
            state          <= RESOLVE;
          end
        end
        LOCKOUT: begin
          // Loaded with LOCKOUT_CYCLES; leaving when it reads 1 gives
          // exactly LOCKOUT_CYCLES cycles of residency.
          lock_cnt <= lock_cnt - CW'(1);
          if (lock_cnt == CW'(1)) begin
            flag_resolve_q <= 1'b1;
            state          <= RESOLVE;
          end
        end
        RESOLVE: begin
          if (!flag) begin
            flag_resolve_q <= 1'b0;
            state          <= ENTRY;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  // Outputs are straight decodes of registered state
  assign inputCount     = count;
  assign userNameInput0 = slot[0];
  assign userNameInput1 = slot[1];
  assign userNameInput2 = slot[2];
  assign userNameInput3 = slot[3];
  assign passwordInput0 = slot[4];
  assign passwordInput1 = slot[5];
  assign passwordInput2 = slot[6];
  assign passwordInput3 = slot[7];
  assign flagResolve    = flag_resolve_q;
  assign entry_full     = (count == 4'd8);
  assign lockout_active = (state == LOCKOUT);

endmodule

// File: tb/tb_credential_entry.sv
// Testbench for credential_entry: directed scenarios followed by random
// stimulus, all checked every cycle against a queue-based reference model.
module tb_credential_entry;

  localparam int LOCK_N = 5;

  logic       clk;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       btn_back;
  logic       btn_clear;
  logic       btn_ack;
  logic       resetCount;
  logic       flag;
  logic       flagSelect;
  logic [3:0] inputCount;
  logic [3:0] userNameInput0, userNameInput1, userNameInput2, userNameInput3;
  logic [3:0] passwordInput0, passwordInput1, passwordInput2, passwordInput3;
  logic       flagResolve;
  logic       entry_full;
  logic       lockout_active;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  credential_entry #(.LOCKOUT_CYCLES(LOCK_N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .digit_valid    (digit_valid),
    .digit          (digit),
    .btn_back       (btn_back),
    .btn_clear      (btn_clear),
    .btn_ack        (btn_ack),
    .resetCount     (resetCount),
    .flag           (flag),
    .flagSelect     (flagSelect),
    .inputCount     (inputCount),
    .userNameInput0 (userNameInput0),
    .userNameInput1 (userNameInput1),
    .userNameInput2 (userNameInput2),
    .userNameInput3 (userNameInput3),
    .passwordInput0 (passwordInput0),
    .passwordInput1 (passwordInput1),
    .passwordInput2 (passwordInput2),
    .passwordInput3 (passwordInput3),
    .flagResolve    (flagResolve),
    .entry_full     (entry_full),
    .lockout_active (lockout_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Modes of the front end as seen by an operator.
  localparam int M_TYPING   = 0;
  localparam int M_WAIT_ACK = 1;
  localparam int M_LOCKED   = 2;
  localparam int M_RESOLVE  = 3;

  logic [3:0] m_digits [$];
  int         m_mode;
  int         m_lock_left;
  logic       m_flag_prev;
  logic       m_rc_prev;

  task automatic model_reset();
    m_digits.delete();
    m_mode      = M_TYPING;
    m_lock_left = 0;
    m_flag_prev = 1'b0;
    m_rc_prev   = 1'b0;
  endtask

  task automatic model_step();
    logic f_rise;
    logic rc_rise;
    f_rise  = flag && !m_flag_prev;
    rc_rise = resetCount && !m_rc_prev;
    case (m_mode)
      M_TYPING: begin
        if (f_rise) begin
          m_digits.delete();
          if (flagSelect) begin
            m_mode      = M_LOCKED;
            m_lock_left = LOCK_N;
          end else begin
            m_mode = M_WAIT_ACK;
          end
        end else if (rc_rise || btn_clear) begin
          m_digits.delete();
        end else if (btn_back) begin
          if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (digit_valid) begin
          if (m_digits.size() < 8) m_digits.push_back(digit);
        end
      end
      M_WAIT_ACK: if (btn_ack) m_mode = M_RESOLVE;
      M_LOCKED: begin
        m_lock_left--;
        if (m_lock_left == 0) m_mode = M_RESOLVE;
      end
      default: if (!flag) m_mode = M_TYPING;
    endcase
    m_flag_prev = flag;
    m_rc_prev   = resetCount;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_nib;
    logic [31:0] got_nib;
    exp_nib = '0;
    for (int k = 0; k < 8; k++)
      if (k < m_digits.size()) exp_nib[4*k +: 4] = m_digits[k];
    got_nib = {passwordInput3, passwordInput2, passwordInput1, passwordInput0,
               userNameInput3, userNameInput2, userNameInput1, userNameInput0};
    check_eq({tag, ".count"}, 32'(inputCount), 32'(m_digits.size()));
    check_eq({tag, ".nibbles"}, got_nib, exp_nib);
    check_eq({tag, ".flagResolve"}, 32'(flagResolve), 32'(m_mode == M_RESOLVE));
    check_eq({tag, ".entry_full"}, 32'(entry_full), 32'(m_digits.size() == 8));
    check_eq({tag, ".lockout"}, 32'(lockout_active), 32'(m_mode == M_LOCKED));
  endtask

  // One clock: advance model with the inputs sampled at the edge, then check.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    cyc++;
    check_all(tag);
    $display("%s cyc=%0d cnt=%0d res=%0b full=%0b lock=%0b", tag, cyc,
             inputCount, flagResolve, entry_full, lockout_active);
    digit_valid = 1'b0;
    btn_back    = 1'b0;
    btn_clear   = 1'b0;
    btn_ack     = 1'b0;
  endtask

  task automatic key(input logic [3:0] d, input string tag);
    digit_valid = 1'b1;
    digit       = d;
    tick(tag);
  endtask

  logic [3:0] plan1 [8];

  initial begin
    rst_n = 1'b1; digit_valid = 1'b0; digit = 4'd0; btn_back = 1'b0;
    btn_clear = 1'b0; btn_ack = 1'b0; resetCount = 1'b0; flag = 1'b0;
    flagSelect = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all("reset");
    tick("reset");
    tick("reset");
    #3 rst_n = 1'b1;

    // Fill the buffer at one digit per two cycles, then overflow attempt.
    plan1 = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0};
    for (int i = 0; i < 8; i++) begin
      key(plan1[i], "fill");
      tick("fill");
    end
    check_eq("fill.user", 32'({userNameInput3, userNameInput2, userNameInput1, userNameInput0}), 32'h0011);
    check_eq("fill.pass", 32'({passwordInput3, passwordInput2, passwordInput1, passwordInput0}), 32'h0011);
    key(4'd7, "overflow");
    tick("overflow");

    // Backspace behaviour.
    btn_clear = 1'b1; tick("clear");
    key(4'd5, "back"); key(4'd6, "back"); key(4'd7, "back");
    btn_back = 1'b1; tick("back");
    btn_back = 1'b1; tick("back");
    key(4'd9, "back");
    check_eq("back.u0", 32'(userNameInput0), 32'd5);
    check_eq("back.u1", 32'(userNameInput1), 32'd9);
    check_eq("back.cnt", 32'(inputCount), 32'd2);
    btn_back = 1'b1; tick("back");
    btn_back = 1'b1; tick("back");
    btn_back = 1'b1; tick("back_empty");

    // resetCount held high clears once and does not block entry.
    for (int i = 0; i < 8; i++) key(4'($urandom_range(15)), "rcload");
    resetCount = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin digit_valid = 1'b1; digit = 4'd4; end
      tick("rchold");
    end
    check_eq("rchold.cnt", 32'(inputCount), 32'd1);
    resetCount = 1'b0; tick("rcdrop");

    // Wrong-password flag racing a digit.
    flag = 1'b1; flagSelect = 1'b0; digit_valid = 1'b1; digit = 4'd3;
    tick("flag0");
    key(4'd2, "hold"); btn_clear = 1'b1; tick("hold");
    btn_ack = 1'b1; tick("ack");
    check_eq("ack.resolve", 32'(flagResolve), 32'd1);
    flag = 1'b0; tick("unflag");
    key(4'd8, "resume");

    // Three-strike lockout.
    flag = 1'b1; flagSelect = 1'b1; tick("lock");
    for (int i = 0; i < LOCK_N + 3; i++) begin
      btn_ack = 1'b1; digit_valid = 1'b1; digit = 4'($urandom_range(15));
      tick("lockrun");
    end
    flag = 1'b0; tick("lockend");
    key(4'd1, "lockresume");

    // Reset in the middle of lockout.
    flag = 1'b1; flagSelect = 1'b1; tick("lock2");
    tick("lock2");
    #2 rst_n = 1'b0; flag = 1'b0; flagSelect = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    tick("in_rst");
    #3 rst_n = 1'b1;
    key(4'd2, "post_rst");
    check_eq("post_rst.cnt", 32'(inputCount), 32'd1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      digit_valid = ($urandom_range(2) == 0);
      digit       = 4'($urandom_range(15));
      btn_back    = ($urandom_range(12) == 0);
      btn_clear   = ($urandom_range(28) == 0);
      btn_ack     = ($urandom_range(6) == 0);
      if ($urandom_range(22) == 0) begin
        flag       = ~flag;
        flagSelect = 1'($urandom_range(1));
      end
      if ($urandom_range(16) == 0) resetCount = ~resetCount;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/credential_entry.md
Name: credential_entry

Overview:
- Front end of the lock datapath; drives the unlocker's entry interface.
- Collects keypad digits into four username nibbles and four password nibbles, and presents a running inputCount.
- Clears its buffer when the unlocker raises resetCount.
- Runs the flag-acknowledge side: operator ack for a wrong password, a timed lockout after the third failure, then a flagResolve handshake back to the unlocker.

Parameters:
- LOCKOUT_CYCLES, 1000, clk cycles entry is disabled after a 3-strike flag (flagSelect=1); must be >=1
- CW, $clog2(LOCKOUT_CYCLES+1), lockout counter width (derived, not overridden)

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- digit_valid  in  1  one-cycle pulse: a debounced keypad digit is present
- digit  in  4  digit value, sampled when digit_valid=1
- btn_back  in  1  one-cycle pulse: delete last digit
- btn_clear  in  1  one-cycle pulse: clear whole buffer
- btn_ack  in  1  one-cycle pulse: operator acknowledges a wrong-password flag
- resetCount  in  1  from unlocker; rising edge = entry consumed, clear buffer
- flag  in  1  from unlocker; error flag
- flagSelect  in  1  from unlocker; 0 = wrong password, 1 = three failed attempts
- inputCount  out  4  digits held, 0..8
- userNameInput0..userNameInput3  out  4 each  digits 1..4 in entry order (digit 1 -> Input0)
- passwordInput0..passwordInput3  out  4 each  digits 5..8 (digit 5 -> passwordInput0)
- flagResolve  out  1  to unlocker; flag has been handled
- entry_full  out  1  level, inputCount==8
- lockout_active  out  1  level, high in LOCKOUT state

Behaviour:
- Reset (rst_n=0, async):
  - inputCount=0; all eight nibbles=0.
  - flagResolve=0, lockout_active=0, entry_full=0.
  - Lockout counter=0; state=ENTRY; resetCount edge register=0.
- All outputs are registered. Each action is visible on the outputs on the clk edge after the input is sampled (1-cycle latency).
- Buffer is eight nibble slots. Slot k (0..7) maps to userNameInput0..3 for k=0..3 and passwordInput0..3 for k=4..7.
- State ENTRY: evaluate in this priority order, one action per cycle:
  1. Rising edge of flag (flag=1, previous sampled flag=0):
     - clear buffer; flag wins over any same-cycle digit or button.
     - if flagSelect=1: load counter with LOCKOUT_CYCLES and go to LOCKOUT.
     - else go to FLAG_HOLD.
  2. Rising edge of resetCount: clear buffer (inputCount=0, all nibbles=0). A held-high resetCount does not block entry.
  3. btn_clear: clear buffer.
  4. btn_back:
     - if inputCount>0: zero slot inputCount-1 and decrement inputCount.
     - at 0: no-op.
  5. digit_valid:
     - if inputCount<8: write digit to slot inputCount and increment.
     - at 8: digit is dropped and nothing changes.
- State FLAG_HOLD:
  - digit_valid, btn_back and btn_clear are ignored; buffer stays 0.
  - btn_ack -> RESOLVE.
- State LOCKOUT:
  - lockout_active=1; all keypad inputs and btn_ack ignored.
  - counter decrements by 1 per cycle; when counter==1 -> RESOLVE on the next edge.
  - Total LOCKOUT residency is exactly LOCKOUT_CYCLES cycles.
- State RESOLVE:
  - flagResolve=1; keypad inputs ignored.
  - Hold until flag is sampled 0, then flagResolve=0 and go to ENTRY on the same edge.
  - If flag is already 0 on entry to RESOLVE, flagResolve pulses for exactly 1 cycle.
- A flag edge seen outside ENTRY is ignored; the unlocker raises at most one flag per evaluation.
- Buffer clear on flag is mandatory: the unlocker re-evaluates every cycle while inputCount==8.
- entry_full and lockout_active are derived from registered state (no combinational path from inputs).
- Reset asserted mid-LOCKOUT or mid-RESOLVE aborts immediately to the reset values; no pending flagResolve survives.

Test Plan:
- Reset, then digits 1,1,0,0,1,1,0,0 at one per 2 cycles:
  - inputCount steps 1..8.
  - userNameInput3..0 = 0,0,1,1 and passwordInput3..0 = 0,0,1,1; entry_full=1.
  - a 9th digit 7 changes nothing.
- Enter 3 digits (5,6,7), btn_back twice, then digit 9:
  - inputCount goes 3->1->2; userNameInput0=5, userNameInput1=9, userNameInput2=0.
- With 8 digits loaded, pulse resetCount high and hold it for 20 cycles:
  - buffer cleared 1 cycle after the rising edge.
  - a digit 4 entered while resetCount is still high is accepted (inputCount=1).
- flag rises with flagSelect=0 in the same cycle as digit_valid:
  - buffer cleared, state FLAG_HOLD, digits ignored.
  - btn_ack -> flagResolve=1; bench drops flag 1 cycle later -> flagResolve=0 next edge, entry resumes.
- LOCKOUT_CYCLES=5, flag rises with flagSelect=1:
  - lockout_active=1 for exactly 5 cycles; btn_ack and digits ignored throughout.
  - then flagResolve=1 until flag=0.
- rst_n pulsed low on cycle 2 of LOCKOUT:
  - all outputs return to 0 asynchronously; after release, a digit is accepted normally.
